// File: rtl/audio_pkg.sv
// Shared audio types for the effects chain front end.
package audio_pkg;

    localparam int SAMPLE_W = 32;

    typedef logic [32:1] sample_t;

    // SYNC: waiting for a right-to-left boundary; LEFT/RIGHT: assembling that channel.
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous codec line, with rising-edge detect.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Shift the raw line through the chain; remember the last synced value for edge detect.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    // Synchroniser and previous-value registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q[STAGES-1];
    assign rise     = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S ADC deserialiser: oversamples bclk/lrck/adcdat on the system clock and
// presents each completed stereo frame with a one-cycle valid strobe.
module i2s_receiver #(
    parameter int SAMPLE_W    = audio_pkg::SAMPLE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bclk,
    input  logic              lrck,
    input  logic              adcdat,
    output logic [SAMPLE_W:1] outleft,
    output logic [SAMPLE_W:1] outright,
    output logic              valid,
    output logic              locked
);

    import audio_pkg::*;

    localparam int CNT_W = $clog2(SAMPLE_W + 1);

    logic tick;
    logic lr;
    logic d;
    logic bclk_sync;
    logic lr_rise;
    logic d_rise;
    logic unused_edges;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clock    (clock),
        .reset    (reset),
        .async_in (bclk),
        .sync_out (bclk_sync),
        .rise     (tick)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .clock    (clock),
        .reset    (reset),
        .async_in (lrck),
        .sync_out (lr),
        .rise     (lr_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_adcdat (
        .clock    (clock),
        .reset    (reset),
        .async_in (adcdat),
        .sync_out (d),
        .rise     (d_rise)
    );

    // Only the bclk edge matters; lrck/adcdat are sampled on that edge.
    assign unused_edges = &{1'b0, lr_rise, d_rise, bclk_sync};

    i2s_state_t          state_q, state_d;
    logic                lr_prev_q, lr_prev_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [SAMPLE_W-1:0] hold_left_q, hold_left_d;
    logic [SAMPLE_W-1:0] outleft_q, outleft_d;
    logic [SAMPLE_W-1:0] outright_q, outright_d;
    logic                valid_q, valid_d;
    logic                locked_q, locked_d;
    logic [SAMPLE_W-1:0] word;

    // Next-state: shift bits MSB-first on each tick, close the word on an lrck change.
    // The boundary tick still carries the LSB slot of the outgoing channel.
    always_comb begin
        state_d     = state_q;
        lr_prev_d   = lr_prev_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        hold_left_d = hold_left_q;
        outleft_d   = outleft_q;
        outright_d  = outright_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        word        = shift_q;

        if (tick) begin
            if (bitcnt_q < CNT_W'(SAMPLE_W)) begin
                word[SAMPLE_W - 1 - int'(bitcnt_q)] = d;
                bitcnt_d = bitcnt_q + CNT_W'(1);
            end
            shift_d   = word;
            lr_prev_d = lr;

            if (lr != lr_prev_q) begin
                shift_d  = '0;
                bitcnt_d = '0;
                case (state_q)
                    SYNC: begin
                        if (!lr) begin
                            state_d = LEFT;
                        end
                    end
                    LEFT: begin
                        if (lr) begin
                            hold_left_d = word;
                            state_d     = RIGHT;
                        end
                    end
                    RIGHT: begin
                        if (!lr) begin
                            outleft_d  = hold_left_q;
                            outright_d = word;
                            valid_d    = 1'b1;
                            locked_d   = 1'b1;
                            state_d    = LEFT;
                        end
                    end
                    default: begin
                        state_d = SYNC;
                    end
                endcase
            end
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= SYNC;
            lr_prev_q   <= 1'b0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            hold_left_q <= '0;
            outleft_q   <= '0;
            outright_q  <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lr_prev_q   <= lr_prev_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            hold_left_q <= hold_left_d;
            outleft_q   <= outleft_d;
            outright_q  <= outright_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
        end
    end

    assign outleft  = outleft_q;
    assign outright = outright_q;
    assign valid    = valid_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: stimulus pushes expected frames, a monitor
// pops and compares on every valid strobe.
module tb_i2s_receiver;

    logic        clock;
    logic        reset;
    logic        bclk;
    logic        lrck;
    logic        adcdat;
    logic [32:1] outleft;
    logic [32:1] outright;
    logic        valid;
    logic        locked;

    i2s_receiver #(.SAMPLE_W(32), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .bclk     (bclk),
        .lrck     (lrck),
        .adcdat   (adcdat),
        .outleft  (outleft),
        .outright (outright),
        .valid    (valid),
        .locked   (locked)
    );

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
    } frame_t;

    frame_t exp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   half = 40;
    logic prev_bit = 1'b0;
    logic left_open = 1'b0;
    logic spacing_on = 1'b0;
    logic have_last = 1'b0;
    time  last_valid = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every valid must match the oldest outstanding expected frame.
    always @(negedge clock) begin
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=%h/%h required=no pulse", outleft, outright);
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                chk("outleft", {32'h0, outleft}, {32'h0, e.l});
                chk("outright", {32'h0, outright}, {32'h0, e.r});
                chk("locked_on_valid", {63'h0, locked}, 64'h1);
            end
            if (spacing_on) begin
                if (have_last) chk("valid_spacing", 64'($time - last_valid), 64'd2560);
                last_valid = $time;
                have_last  = 1'b1;
            end
        end
    end

    task automatic send_tick(input logic lr, input logic d);
        lrck   = lr;
        adcdat = d;
        #(half);
        bclk = 1'b1;
        #(half);
        bclk = 1'b0;
    endtask

    // Data trails lrck by one bclk: each tick carries the previous slot bit.
    task automatic send_slot(input logic ch, input logic [63:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (!(i == 0 && left_open && ch == 1'b0)) send_tick(ch, prev_bit);
            prev_bit = w[63 - i];
        end
        left_open = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int nbits);
        send_slot(1'b0, l, nbits);
        send_slot(1'b1, r, nbits);
    endtask

    // Opening tick of the next left slot: delivers the right LSB and closes the frame.
    task automatic close_frame();
        if (!left_open) send_tick(1'b0, prev_bit);
        left_open = 1'b1;
    endtask

    task automatic push(input logic [31:0] l, input logic [31:0] r);
        frame_t f;
        f.l = l;
        f.r = r;
        exp_q.push_back(f);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (10) @(posedge clock);
    endtask

    initial begin
        logic        idle_bad;
        logic [31:0] rl, rr;
        reset  = 1'b1;
        bclk   = 1'b0;
        lrck   = 1'b0;
        adcdat = 1'b0;
        #3;
        repeat (5) @(posedge clock);
        #3;
        chk("reset_outleft", {32'h0, outleft}, 64'h0);
        chk("reset_outright", {32'h0, outright}, 64'h0);
        chk("reset_valid_locked", {62'h0, valid, locked}, 64'h0);
        reset = 1'b0;

        idle_bad = 1'b0;
        repeat (1000) begin
            @(negedge clock);
            if (outleft !== 32'h0 || outright !== 32'h0 || valid !== 1'b0 || locked !== 1'b0)
                idle_bad = 1'b1;
        end
        chk("idle_hold", {63'h0, idle_bad}, 64'h0);
        #3;

        half = 40;
        send_frame({32'h8000_0001, 32'h0}, {32'h7FFF_FFFE, 32'h0}, 32);
        push(32'h8000_0001, 32'h7FFF_FFFE);
        send_frame({32'h8000_0001, 32'h0}, {32'h7FFF_FFFE, 32'h0}, 32);
        push(32'h8000_0001, 32'h7FFF_FFFE);
        send_frame({32'h8000_0001, 32'h0}, {32'h7FFF_FFFE, 32'h0}, 32);
        close_frame();
        drain("drain_32bit");
        chk("locked_sticky", {63'h0, locked}, 64'h1);

        push(32'hABCD_EF00, 32'h1234_5600);
        send_frame({24'hABCDEF, 40'h0}, {24'h123456, 40'h0}, 24);
        close_frame();
        drain("drain_24bit");

        push(32'hDEAD_BEEF, 32'h0F0F_0F0F);
        send_frame({32'hDEAD_BEEF, 8'hFF, 24'h0}, {32'h0F0F_0F0F, 8'hFF, 24'h0}, 40);
        close_frame();
        drain("drain_40bit");

        send_slot(1'b0, {32'hCAFE_F00D, 32'h0}, 32);
        send_slot(1'b1, {32'h5555_AAAA, 32'h0}, 16);
        reset = 1'b1;
        #7;
        chk("midreset_outleft", {32'h0, outleft}, 64'h0);
        chk("midreset_outright", {32'h0, outright}, 64'h0);
        chk("midreset_locked", {63'h0, locked}, 64'h0);
        #10;
        reset = 1'b0;
        #20;
        send_slot(1'b1, {32'hAAAA_0000, 32'h0}, 16);
        push(32'h1234_5678, 32'h9ABC_DEF0);
        send_frame({32'h1234_5678, 32'h0}, {32'h9ABC_DEF0, 32'h0}, 32);
        close_frame();
        drain("drain_after_reset");

        half = 20;
        spacing_on = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rl = $urandom;
            rr = $urandom;
            push(rl, rr);
            send_frame({rl, 32'h0}, {rr, 32'h0}, 32);
        end
        close_frame();
        drain("drain_random");
        spacing_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
